keyed_gpr_file: RTL and testbench

- General-purpose register file for the RV64 single-cycle core, instantiated by the decode stage.
- NR_REG registers of XLEN bits; register 0 is hard-wired to zero.
- Write-enable selection uses a key-lookup multiplexer: destination index → one-hot enable vector, all-zero default on no match.
- Two combinational read ports feed src1/src2; one synchronous write port takes the execute result.

---
 rtl/keyed_gpr_file.sv | 74 +++++++
 tb/tb_keyed_gpr_file.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/keyed_gpr_file.sv
// keyed_gpr_file: XLEN-bit general-purpose register file with x0 hard-wired
// to zero, two combinational read ports and one synchronous write port.
// The write port decodes its index through a key-lookup one-hot table.
module keyed_gpr_file #(
  parameter int unsigned     XLEN      = 64,
  parameter int unsigned     NR_REG    = 32,
  parameter int unsigned     REG_SEL   = 5,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wen,
  input  logic [REG_SEL-1:0] waddr,
  input  logic [XLEN-1:0]    wdata,
  input  logic [REG_SEL-1:0] raddr1,
  input  logic [REG_SEL-1:0] raddr2,
  output logic [XLEN-1:0]    rdata1,
  output logic [XLEN-1:0]    rdata2
);

  // One-hot write select; all zero when waddr names no register.
  logic [NR_REG-1:0] wsel;

  // Registers 1..NR_REG-1 only; x0 has no storage at all.
  logic [XLEN-1:0] regs_q [1:NR_REG-1];
  logic [XLEN-1:0] regs_d [1:NR_REG-1];

  // Key-lookup decode: entry k carries a one-hot vector with bit k set.
  always_comb begin
    wsel = '0;
    for (int unsigned k = 0; k < NR_REG; k++) begin
      if (waddr == REG_SEL'(k)) begin
        wsel = NR_REG'(1) << k;
      end
    end
  end

  // Next value per register: load wdata when globally and locally enabled.
  // Bit 0 of the decode is never consulted, which keeps x0 unwritable.
  always_comb begin
    for (int unsigned k = 1; k < NR_REG; k++) begin
      regs_d[k] = regs_q[k];
      if (wen && wsel[k]) begin
        regs_d[k] = wdata;
      end
    end
  end

  // Register update; synchronous active-low reset wins over any write.
  always_ff @(posedge clk) begin
    for (int unsigned k = 1; k < NR_REG; k++) begin
      if (!rst) begin
        regs_q[k] <= RESET_VAL;
      end else begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  // Combinational read ports, no bypass; index 0 and out-of-range read zero.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    for (int unsigned k = 1; k < NR_REG; k++) begin
      if (raddr1 == REG_SEL'(k)) begin
        rdata1 = regs_q[k];
      end
      if (raddr2 == REG_SEL'(k)) begin
        rdata2 = regs_q[k];
      end
    end
  end

endmodule

// File: tb/tb_keyed_gpr_file.sv
// Testbench for keyed_gpr_file: directed sequences plus random traffic,
// checked through a scoreboard against an array-based reference model.
// A second instance with fewer registers and a nonzero reset value covers
// out-of-range indices and RESET_VAL loading.
module tb_keyed_gpr_file;

  localparam int unsigned     NR_SMALL = 20;
  localparam logic [63:0]     RV_SMALL = 64'h0BAD_F00D_0000_0001;

  logic        clk;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [63:0] rdata1_b, rdata2_b;
  logic [63:0] rdata1_s, rdata2_s;

  keyed_gpr_file #(
    .XLEN(64), .NR_REG(32), .REG_SEL(5), .RESET_VAL(64'h0)
  ) dut_big (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b), .rdata2(rdata2_b)
  );

  keyed_gpr_file #(
    .XLEN(64), .NR_REG(NR_SMALL), .REG_SEL(5), .RESET_VAL(RV_SMALL)
  ) dut_small (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_s), .rdata2(rdata2_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] b1, b2, s1, s2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural contents, x0 is always zero.
  logic [63:0] mb [32];
  logic [63:0] ms [32];
  bit          mvalid = 1'b0;

  function automatic logic [63:0] rd_big(input logic [4:0] a);
    return (a == 5'd0) ? 64'h0 : mb[a];
  endfunction

  function automatic logic [63:0] rd_small(input logic [4:0] a);
    return (a == 5'd0 || a >= NR_SMALL) ? 64'h0 : ms[a];
  endfunction

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // One clock cycle: drive, record pre-edge read expectation, then advance the
  // model by what the coming edge does.
  task automatic cyc(input logic r, input logic w, input logic [4:0] wa,
                     input logic [63:0] wd, input logic [4:0] a1,
                     input logic [4:0] a2, input string n);
    exp_t e;
    @(negedge clk);
    rst = r; wen = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
    #1;
    if (mvalid) begin
      e.name = n;
      e.b1 = rd_big(a1);   e.b2 = rd_big(a2);
      e.s1 = rd_small(a1); e.s2 = rd_small(a2);
      sb.push_back(e);
    end
    if (!r) begin
      for (int i = 1; i < 32; i++) mb[i] = 64'h0;
      for (int i = 1; i < 32; i++) ms[i] = RV_SMALL;
      mvalid = 1'b1;
    end else if (w && wa != 5'd0) begin
      mb[wa] = wd;
      if (wa < NR_SMALL) ms[wa] = wd;
    end
  endtask

  // Monitor: reads are combinational, so every cycle presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".big.r1"},   rdata1_b, e.b1);
        check({e.name, ".big.r2"},   rdata2_b, e.b2);
        check({e.name, ".small.r1"}, rdata1_s, e.s1);
        check({e.name, ".small.r2"}, rdata2_s, e.s2);
      end
    end
  end

  initial begin
    logic [4:0] a, b;
    rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;

    // Reset with a concurrent write that must be ignored.
    cyc(1'b0, 1'b1, 5'd5, 64'hDEAD, 5'd5, 5'd0, "reset");
    for (int i = 0; i < 32; i++) begin
      a = 5'(i); b = 5'(31 - i);
      cyc(1'b1, 1'b0, 5'd0, 64'h0, a, b, "after_reset");
    end

    // Basic write; pre-edge read still shows the old value.
    cyc(1'b1, 1'b1, 5'd1, 64'h1234_5678_9ABC_DEF0, 5'd1, 5'd1, "wr1_pre");
    cyc(1'b1, 1'b0, 5'd0, 64'h0, 5'd1, 5'd0, "wr1_post");

    // x0 immutable.
    cyc(1'b1, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd1, "x0_wr");
    cyc(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd1, "x0_rd");

    // Write-enable gating, then both ports on the same index.
    cyc(1'b1, 1'b0, 5'd2, 64'h55, 5'd2, 5'd2, "gate_off");
    cyc(1'b1, 1'b1, 5'd2, 64'h55, 5'd2, 5'd2, "gate_on");
    cyc(1'b1, 1'b0, 5'd0, 64'h0, 5'd2, 5'd2, "gate_rd");

    // One-hot decode sweep, then read everything back.
    for (int k = 1; k < 32; k++) begin
      a = 5'(k); b = 5'(k - 1);
      cyc(1'b1, 1'b1, a, (64'(k) << 8) | 64'(k), a, b, "sweep_wr");
    end
    for (int k = 0; k < 32; k++) begin
      a = 5'(k); b = 5'(31 - k);
      cyc(1'b1, 1'b0, 5'd0, 64'h0, a, b, "sweep_rd");
    end

    // Reset mid-operation beats a concurrent write; writes resume next cycle.
    cyc(1'b0, 1'b1, 5'd3, 64'h77, 5'd3, 5'd31, "mid_reset");
    cyc(1'b1, 1'b1, 5'd3, 64'h77, 5'd3, 5'd31, "post_reset_wr");
    cyc(1'b1, 1'b0, 5'd0, 64'h0, 5'd3, 5'd19, "post_reset_rd");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 24) != 0), 1'($urandom), 5'($urandom_range(0, 31)),
          {$urandom, $urandom}, 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), "random");
    end

    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
